// File: rtl/iob_cache_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iob_cache_ctrl_pkg
// Shared definitions for the cache control-port initiator:
//   - command op encodings (op_t)
//   - status codes reported on err_o (err_t)
//   - FSM state encoding (state_t)
//   - register addresses for every step, taken from the IOB_CACHE_*_ADDR
//     definitions (defaults below apply when the cache build does not
//     provide them)
//   - step_addr(): maps (op, step index) to the register address
// No ports (package).
// ----------------------------------------------------------------------------
`ifndef IOB_CACHE_SWREG_ADDR_W
`define IOB_CACHE_SWREG_ADDR_W 5
`endif
`ifndef IOB_CACHE_WTB_EMPTY_ADDR
`define IOB_CACHE_WTB_EMPTY_ADDR 1
`endif
`ifndef IOB_CACHE_RST_CNTRS_ADDR
`define IOB_CACHE_RST_CNTRS_ADDR 2
`endif
`ifndef IOB_CACHE_READ_HIT_ADDR
`define IOB_CACHE_READ_HIT_ADDR 3
`endif
`ifndef IOB_CACHE_READ_MISS_ADDR
`define IOB_CACHE_READ_MISS_ADDR 4
`endif
`ifndef IOB_CACHE_WRITE_HIT_ADDR
`define IOB_CACHE_WRITE_HIT_ADDR 5
`endif
`ifndef IOB_CACHE_WRITE_MISS_ADDR
`define IOB_CACHE_WRITE_MISS_ADDR 6
`endif
`ifndef IOB_CACHE_INVALIDATE_ADDR
`define IOB_CACHE_INVALIDATE_ADDR 7
`endif
`ifndef IOB_CACHE_VERSION_ADDR
`define IOB_CACHE_VERSION_ADDR 8
`endif

package iob_cache_ctrl_pkg;

    localparam int SWREG_ADDR_W = `IOB_CACHE_SWREG_ADDR_W;

    typedef enum logic [1:0] {
        OP_SNAPSHOT  = 2'd0,
        OP_CLEAR     = 2'd1,
        OP_FLUSH_INV = 2'd2,
        OP_VERSION   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_POLL    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ADDR_WTB_EMPTY  = `IOB_CACHE_WTB_EMPTY_ADDR;
    localparam int ADDR_RST_CNTRS  = `IOB_CACHE_RST_CNTRS_ADDR;
    localparam int ADDR_READ_HIT   = `IOB_CACHE_READ_HIT_ADDR;
    localparam int ADDR_READ_MISS  = `IOB_CACHE_READ_MISS_ADDR;
    localparam int ADDR_WRITE_HIT  = `IOB_CACHE_WRITE_HIT_ADDR;
    localparam int ADDR_WRITE_MISS = `IOB_CACHE_WRITE_MISS_ADDR;
    localparam int ADDR_INVALIDATE = `IOB_CACHE_INVALIDATE_ADDR;
    localparam int ADDR_VERSION    = `IOB_CACHE_VERSION_ADDR;

    // FLUSH_INV uses step 0 for the WTB_EMPTY poll and step 1 for INVALIDATE.
    function automatic int step_addr(op_t op, logic [1:0] step);
        int a;
        a = ADDR_VERSION;
        case (op)
            OP_SNAPSHOT: begin
                case (step)
                    2'd0:    a = ADDR_READ_HIT;
                    2'd1:    a = ADDR_READ_MISS;
                    2'd2:    a = ADDR_WRITE_HIT;
                    default: a = ADDR_WRITE_MISS;
                endcase
            end
            OP_CLEAR:     a = ADDR_RST_CNTRS;
            OP_FLUSH_INV: a = (step == 2'd0) ? ADDR_WTB_EMPTY : ADDR_INVALIDATE;
            default:      a = ADDR_VERSION;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/iob_cache_ctrl_wdog.sv
// ----------------------------------------------------------------------------
// iob_cache_ctrl_wdog
// Response watchdog: loadable down-counter with an expire flag. Exists only
// when IOB_CACHE_CTRL_WDOG_EN is defined.
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   load_i     reload the counter with LIMIT-1
//   en_i       count down while high
//   expired_o  high while enabled and the counter has reached zero, i.e. on
//              the LIMIT-th enabled cycle after a load
// ----------------------------------------------------------------------------
`ifdef IOB_CACHE_CTRL_WDOG_EN
module iob_cache_ctrl_wdog #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= CNT_W'(LIMIT - 1);
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired_o = en_i && (cnt == '0);

endmodule
`endif

// File: rtl/iob_cache_ctrl_master.sv
// ----------------------------------------------------------------------------
// iob_cache_ctrl_master
// Turns single host commands (counter snapshot, counter clear, write-through
// buffer drain + invalidate, version readout) into register request
// sequences on the cache control port.
// Optional feature: IOB_CACHE_CTRL_WDOG_EN enables a response watchdog that
// aborts a command when a WAIT lasts RESP_TO cycles (err_o = 2).
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_op_i      command request; accepted when cmd_ready_o
//   cmd_ready_o               high only while idle
//   ctrl_valid_o/ctrl_addr_o  one-cycle register request toward the cache
//   ctrl_ready_i/ctrl_rdata_i response strobe and data (data valid with strobe)
//   read_hit_o .. write_miss_o last committed counter snapshot
//   version_o                 last version read
//   busy_o, done_o, err_o     status; err_o held until the next command
// Handshake: a command transfers on a clock edge where cmd_valid_i and
// cmd_ready_o are both high; the requester holds cmd_valid_i until then.
// A request is the single cycle ctrl_valid_o is high; its response is the
// first cycle ctrl_ready_i is high while waiting; strobes at other times are
// ignored.
// ----------------------------------------------------------------------------
module iob_cache_ctrl_master
    import iob_cache_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = SWREG_ADDR_W,
    parameter int POLL_MAX = 1024,
    parameter int RESP_TO  = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_op_i,
    output logic              cmd_ready_o,
    output logic              ctrl_valid_o,
    output logic [ADDR_W-1:0] ctrl_addr_o,
    input  logic              ctrl_ready_i,
    input  logic [DATA_W-1:0] ctrl_rdata_i,
    output logic [DATA_W-1:0] read_hit_o,
    output logic [DATA_W-1:0] read_miss_o,
    output logic [DATA_W-1:0] write_hit_o,
    output logic [DATA_W-1:0] write_miss_o,
    output logic [DATA_W-1:0] version_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o
);

    localparam int PCNT_W = $clog2(POLL_MAX + 1);

    if (POLL_MAX < 1) begin : g_bad_poll_max
        $error("POLL_MAX must be at least 1");
    end
    if (RESP_TO < 2) begin : g_bad_resp_to
        $error("RESP_TO must be at least 2");
    end

    state_t            state;
    op_t               op;
    logic [1:0]        step;
    logic [PCNT_W-1:0] poll_cnt;
    logic [DATA_W-1:0] shadow [4];

    logic              nxt_issue;
    logic [1:0]        nxt_step;
    logic              poll_fail;
    logic              wdog_expired;

`ifdef IOB_CACHE_CTRL_WDOG_EN
    iob_cache_ctrl_wdog #(
        .LIMIT(RESP_TO)
    ) u_wdog (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .load_i   (state == ST_ISSUE),
        .en_i     (state == ST_WAIT),
        .expired_o(wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    assign cmd_ready_o = (state == ST_IDLE);

    // Decision taken in NEXT: another request, or finish.
    always_comb begin
        nxt_issue = 1'b0;
        nxt_step  = step;
        poll_fail = 1'b0;
        case (op)
            OP_SNAPSHOT: begin
                if (step != 2'd3) begin
                    nxt_issue = 1'b1;
                    nxt_step  = step + 2'd1;
                end
            end
            OP_FLUSH_INV: begin
                if (step == 2'd0) begin
                    if (shadow[0][0]) begin
                        nxt_issue = 1'b1;
                        nxt_step  = 2'd1;
                    end else if (poll_cnt < PCNT_W'(POLL_MAX)) begin
                        nxt_issue = 1'b1;
                        nxt_step  = 2'd0;
                    end else begin
                        poll_fail = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= ST_IDLE;
            op           <= OP_SNAPSHOT;
            step         <= 2'd0;
            poll_cnt     <= '0;
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
            ctrl_valid_o <= 1'b0;
            ctrl_addr_o  <= '0;
            read_hit_o   <= '0;
            read_miss_o  <= '0;
            write_hit_o  <= '0;
            write_miss_o <= '0;
            version_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= ERR_OK;
        end else begin
            ctrl_valid_o <= 1'b0;
            done_o       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op           <= op_t'(cmd_op_i);
                        err_o        <= ERR_OK;
                        step         <= 2'd0;
                        poll_cnt     <= '0;
                        // Request is raised on the accept edge so it is
                        // visible during the ISSUE cycle.
                        ctrl_valid_o <= 1'b1;
                        ctrl_addr_o  <= ADDR_W'(step_addr(op_t'(cmd_op_i), 2'd0));
                        busy_o       <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (ctrl_ready_i) begin
                        shadow[step] <= ctrl_rdata_i;
                        if ((op == OP_FLUSH_INV) && (step == 2'd0) &&
                            (poll_cnt != PCNT_W'(POLL_MAX))) begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                        state <= ST_NEXT;
                    end else if (wdog_expired) begin
                        err_o  <= ERR_TIMEOUT;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_NEXT: begin
                    if (nxt_issue) begin
                        step         <= nxt_step;
                        ctrl_valid_o <= 1'b1;
                        ctrl_addr_o  <= ADDR_W'(step_addr(op, nxt_step));
                        state        <= ST_ISSUE;
                    end else begin
                        // Outputs commit on the same edge that raises done_o.
                        if (op == OP_SNAPSHOT) begin
                            read_hit_o   <= shadow[0];
                            read_miss_o  <= shadow[1];
                            write_hit_o  <= shadow[2];
                            write_miss_o <= shadow[3];
                        end
                        if (op == OP_VERSION) version_o <= shadow[0];
                        if (poll_fail) err_o <= ERR_POLL;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cache_ctrl_master.sv
// ----------------------------------------------------------------------------
// tb_iob_cache_ctrl_master
// Bench for iob_cache_ctrl_master: a responder process answers requests after
// a queued delay with queued data and records every request address; a
// reference model predicts the request list, outputs, status and completion
// cycle of each command from the command rules.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iob_cache_ctrl_master;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = `IOB_CACHE_SWREG_ADDR_W;
    localparam int POLL_MAX = 3;
    localparam int RESP_TO  = 16;

    localparam logic [ADDR_W-1:0] A_WTB = ADDR_W'(`IOB_CACHE_WTB_EMPTY_ADDR);
    localparam logic [ADDR_W-1:0] A_RST = ADDR_W'(`IOB_CACHE_RST_CNTRS_ADDR);
    localparam logic [ADDR_W-1:0] A_INV = ADDR_W'(`IOB_CACHE_INVALIDATE_ADDR);
    localparam logic [ADDR_W-1:0] A_VER = ADDR_W'(`IOB_CACHE_VERSION_ADDR);

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic              cmd_ready;
    logic              ctrl_valid;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              ctrl_ready;
    logic [DATA_W-1:0] ctrl_rdata;
    logic [DATA_W-1:0] read_hit, read_miss, write_hit, write_miss, version;
    logic              busy, done;
    logic [1:0]        err;

    iob_cache_ctrl_master #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .POLL_MAX(POLL_MAX),
        .RESP_TO (RESP_TO)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .cmd_valid_i (cmd_valid),
        .cmd_op_i    (cmd_op),
        .cmd_ready_o (cmd_ready),
        .ctrl_valid_o(ctrl_valid),
        .ctrl_addr_o (ctrl_addr),
        .ctrl_ready_i(ctrl_ready),
        .ctrl_rdata_i(ctrl_rdata),
        .read_hit_o  (read_hit),
        .read_miss_o (read_miss),
        .write_hit_o (write_hit),
        .write_miss_o(write_miss),
        .version_o   (version),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] m_rh, m_rm, m_wh, m_wm, m_ver;
    logic [ADDR_W-1:0] snap_a [4];
    logic [DATA_W-1:0] fix_d  [4];

    int                dly_q [$];
    logic [DATA_W-1:0] dat_q [$];
    logic [ADDR_W-1:0] obs_q [$];
    bit                silent;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- responder ----------------
    initial begin : responder
        int cnt;
        logic [DATA_W-1:0] cur;
        cnt = 0;
        cur = '0;
        ctrl_ready = 1'b0;
        ctrl_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            ctrl_ready = 1'b0;
            ctrl_rdata = $urandom;
            if (!reset_n || silent) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ctrl_ready = 1'b1;
                    ctrl_rdata = cur;
                end
            end else if (!busy && ($urandom_range(0, 3) == 0)) begin
                // stray strobe while idle must be ignored
                ctrl_ready = 1'b1;
            end
            if (ctrl_valid && reset_n) begin
                obs_q.push_back(ctrl_addr);
                cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
                cur = (dat_q.size() > 0) ? dat_q.pop_front() : '0;
                if (silent) cnt = 0;
            end
        end
    end

    // ---------------- driver + model ----------------
    task automatic run_cmd(input logic [1:0] op, input int zeros, input bit directed, input bit sil);
        logic [DATA_W-1:0] d [4];
        logic [ADDR_W-1:0] exp_a [$];
        logic [127:0]      old_snap;
        logic [DATA_W-1:0] old_ver;
        logic [DATA_W-1:0] v;
        logic [1:0]        exp_err;
        int                lat, polls, dl, done_k;
        bit                ready_now, seen;

        exp_err = 2'd0;
        lat     = 1;
        seen    = 1'b0;
        done_k  = 0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        obs_q.delete();
        dly_q.delete();
        dat_q.delete();

        case (op)
            2'd0: begin
                for (int i = 0; i < 4; i++) begin
                    d[i] = directed ? fix_d[i] : DATA_W'($urandom);
                    exp_a.push_back(snap_a[i]);
                    dat_q.push_back(d[i]);
                end
            end
            2'd1: begin
                exp_a.push_back(A_RST);
                dat_q.push_back($urandom);
            end
            2'd2: begin
                polls = (zeros < POLL_MAX) ? zeros + 1 : POLL_MAX;
                for (int p = 0; p < polls; p++) begin
                    v    = $urandom;
                    v[0] = (p == zeros);
                    exp_a.push_back(A_WTB);
                    dat_q.push_back(v);
                end
                if (zeros < POLL_MAX) begin
                    exp_a.push_back(A_INV);
                    dat_q.push_back($urandom);
                end else begin
                    exp_err = 2'd1;
                end
            end
            default: begin
                d[0] = $urandom;
                exp_a.push_back(A_VER);
                dat_q.push_back(d[0]);
            end
        endcase

        if (sil) begin
            while (exp_a.size() > 1) void'(exp_a.pop_back());
            exp_err = 2'd2;
            lat     = RESP_TO + 2;
        end else begin
            for (int i = 0; i < exp_a.size(); i++) begin
                dl = directed ? 1 : $urandom_range(1, 4);
                dly_q.push_back(dl);
                lat += 2 + dl;
            end
        end
        silent   = sil;
        old_snap = {m_rh, m_rm, m_wh, m_wm};
        old_ver  = m_ver;

        // accept
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            ready_now = cmd_ready;
            @(posedge clk);
            if (ready_now) break;
            #1;
        end
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);

        // wait for completion; committed values must not move before done
        for (int k = 1; k <= lat + RESP_TO + 20; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                seen   = 1'b1;
                done_k = k;
                break;
            end
            chk($sformatf("hold_before_done op%0d", op), {read_hit, read_miss, write_hit, write_miss}, old_snap);
        end
        chk($sformatf("done_seen op%0d", op), seen, 1'b1);
        if (seen) chk($sformatf("done_cycle op%0d", op), done_k, lat);

        if (!sil) begin
            if (op == 2'd0) begin
                m_rh = d[0]; m_rm = d[1]; m_wh = d[2]; m_wm = d[3];
            end
            if (op == 2'd3) m_ver = d[0];
        end
        chk($sformatf("snapshot op%0d", op), {read_hit, read_miss, write_hit, write_miss}, {m_rh, m_rm, m_wh, m_wm});
        chk($sformatf("version op%0d", op), version, m_ver);
        chk($sformatf("err op%0d", op), err, exp_err);
        chk($sformatf("req_count op%0d", op), obs_q.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i < obs_q.size()) chk($sformatf("req_addr op%0d #%0d", op, i), obs_q[i], exp_a[i]);
        end
        if (!sil && op != 2'd3) chk("version_untouched", version, old_ver);

        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", {cmd_ready, busy}, 2'b10);
        chk("err_held", err, exp_err);
        silent = 1'b0;
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [DATA_W-1:0] v;
        int acc_k, done_k;
        bit rn, seen;

        snap_a[0] = ADDR_W'(`IOB_CACHE_READ_HIT_ADDR);
        snap_a[1] = ADDR_W'(`IOB_CACHE_READ_MISS_ADDR);
        snap_a[2] = ADDR_W'(`IOB_CACHE_WRITE_HIT_ADDR);
        snap_a[3] = ADDR_W'(`IOB_CACHE_WRITE_MISS_ADDR);
        fix_d[0] = 32'd5; fix_d[1] = 32'd2; fix_d[2] = 32'd7; fix_d[3] = 32'd1;
        m_rh = '0; m_rm = '0; m_wh = '0; m_wm = '0; m_ver = '0;
        silent    = 1'b0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {read_hit, read_miss, write_hit, write_miss}, 128'd0);
        chk("reset_version", version, 32'd0);
        chk("reset_ctrl", {ctrl_valid, ctrl_addr}, '0);
        chk("reset_status", {cmd_ready, busy, done, err}, 5'b10000);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        run_cmd(2'd0, 0, 1'b1, 1'b0);   // snapshot 5,2,7,1
        run_cmd(2'd1, 0, 1'b1, 1'b0);   // clear
        run_cmd(2'd3, 0, 1'b1, 1'b0);   // version
        run_cmd(2'd2, 2, 1'b1, 1'b0);   // WTB_EMPTY reads 0,0,1
        run_cmd(2'd2, POLL_MAX, 1'b1, 1'b0);  // never empty
`ifdef IOB_CACHE_CTRL_WDOG_EN
        run_cmd(2'd0, 0, 1'b1, 1'b1);   // silent responder
`endif

        // held command: VERSION requested while CLEAR is busy
        obs_q.delete(); dly_q.delete(); dat_q.delete();
        dly_q.push_back(1); dat_q.push_back($urandom);
        v = $urandom;
        dly_q.push_back(1); dat_q.push_back(v);
        cmd_op    = 2'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_op = 2'd3;
        acc_k  = 0;
        done_k = 0;
        for (int k = 1; k <= 40; k++) begin
            rn = cmd_ready;
            @(posedge clk);
            if (rn) begin
                acc_k = k;
                break;
            end
            #1;
            if (done && done_k == 0) done_k = k;
        end
        #1;
        cmd_valid = 1'b0;
        chk("held_clear_done_cycle", done_k + 1, 4);
        chk("held_accept_edge", acc_k, done_k + 2);
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        m_ver = v;
        chk("held_version_done", seen, 1'b1);
        chk("held_version", version, m_ver);
        chk("held_req_count", obs_q.size(), 2);
        if (obs_q.size() >= 2) chk("held_req_addrs", {obs_q[0], obs_q[1]}, {A_RST, A_VER});
        @(posedge clk);
        #1;

        // randomized commands
        for (int n = 0; n < 40; n++) begin
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, POLL_MAX + 1), 1'b0, 1'b0);
        end

        // reset during the third snapshot read
        run_cmd(2'd0, 0, 1'b0, 1'b0);
        obs_q.delete(); dly_q.delete(); dat_q.delete();
        for (int i = 0; i < 4; i++) begin
            dly_q.push_back(1);
            dat_q.push_back($urandom);
        end
        cmd_op    = 2'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            if (obs_q.size() == 3) begin
                seen = 1'b1;
                break;
            end
        end
        chk("third_read_reached", seen, 1'b1);
        reset_n = 1'b0;
        #1;
        m_rh = '0; m_rm = '0; m_wh = '0; m_wm = '0; m_ver = '0;
        chk("midreset_outputs", {read_hit, read_miss, write_hit, write_miss}, 128'd0);
        chk("midreset_version", version, 32'd0);
        chk("midreset_status", {cmd_ready, busy, done, ctrl_valid, err}, 6'b100000);
        dly_q.delete(); dat_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_ready", {cmd_ready, busy}, 2'b10);
        run_cmd(2'd0, 0, 1'b0, 1'b0);
        run_cmd(2'd2, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_cache_ctrl_master.md
# iob_cache_ctrl_master

Initiator for the cache's control/status register port: it turns single host commands into short sequences of register requests toward the cache controller. Supported sequences: counter snapshot, counter clear, write-through-buffer drain followed by invalidate, and version readout. Sits between a host/CSR front end and the cache's control port. Removes polling loops and multi-read sequencing from software.

## Interface
- DATA_W, 32, control-port read data width and counter width
- ADDR_W, `IOB_CACHE_SWREG_ADDR_W`, control-port address width
- POLL_MAX, 1024, maximum write-through-buffer-empty polls before abort (≥1)
- RESP_TO, 16, response watchdog limit in cycles (≥2; used only with the watchdog)
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_op_i  in  2  0 SNAPSHOT, 1 CLEAR, 2 FLUSH_INV, 3 VERSION
- cmd_ready_o  out  1  high only in IDLE
- ctrl_valid_o  out  1  control-port request, one-cycle pulse
- ctrl_addr_o  out  ADDR_W  control-port register address
- ctrl_ready_i  in  1  control-port response strobe
- ctrl_rdata_i  in  DATA_W  response data, valid while ctrl_ready_i is high
- read_hit_o, read_miss_o, write_hit_o, write_miss_o  out  DATA_W each  last committed snapshot
- version_o  out  DATA_W  last version read
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  2  status of the last command: 0 ok, 1 poll exhausted, 2 response timeout; held until the next command

## Operation
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
- Command is accepted on the edge where cmd_valid_i && cmd_ready_o. On accept: latch the op, clear err_o, clear step and poll counters, go to ISSUE.
- ISSUE: drive ctrl_valid_o=1 and ctrl_addr_o = address for the current step; go to WAIT.
- WAIT: ctrl_valid_o=0. On ctrl_ready_i, capture ctrl_rdata_i into the step's shadow register, then go to NEXT.
- NEXT: choose the following step or DONE, per op.
- Step sequences:
  - SNAPSHOT: READ_HIT, READ_MISS, WRITE_HIT, WRITE_MISS addresses. Shadows commit to all four outputs together in DONE; outputs never show a mix of old and new values.
  - CLEAR: RST_CNTRS address only; rdata is ignored.
  - FLUSH_INV: poll WTB_EMPTY.
    - rdata[0]=1: next step is INVALIDATE, then DONE.
    - rdata[0]=0 and fewer than POLL_MAX polls issued: reissue.
    - rdata[0]=0 and POLL_MAX polls reached: err_o=1, go to DONE, no invalidate issued.
  - VERSION: VERSION address; version_o updates in DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- ctrl_ready_i outside WAIT is ignored.
- cmd_valid_i while busy is not accepted; the requester must hold it.
- Poll counter width is $clog2(POLL_MAX+1) and saturates; it never wraps.
- Reset asserted mid-sequence: FSM goes to IDLE immediately. The partially read SNAPSHOT is discarded; previously committed outputs also reset to 0.

## Timing
- Reset values:
  - all data outputs: 0
  - ctrl_valid_o, ctrl_addr_o, busy_o, done_o: 0
  - err_o: 0
  - cmd_ready_o: 1
- All outputs are registered except cmd_ready_o, which is decoded from the state register.
- Per transaction: ISSUE 1 cycle + WAIT ≥1 cycle + NEXT 1 cycle. With a responder that answers the cycle after the request, that is 3 cycles.
- Accept at edge 0 gives ctrl_valid_o high in cycle 1.
- Latency from accept to done_o pulse, for a responder that answers the cycle after the request:
  - SNAPSHOT: cycle 13
  - CLEAR and VERSION: cycle 4
  - FLUSH_INV: 3·(polls+1)+1
- Back-to-back commands: the next one can be accepted in the cycle after done_o.

## Configuration
- `IOB_CACHE_CTRL_WDOG_EN` defined: a WAIT lasting RESP_TO cycles without ctrl_ready_i aborts the command. Abort sets err_o=2, goes to DONE, commits no shadows, and issues no further requests.
- Macro undefined: WAIT lasts indefinitely and err_o never takes value 2.

## Structure
- Shared package iob_cache_ctrl_pkg holds:
  - op encodings
  - error codes
  - FSM state encoding
  - step-to-address mapping constants, built from the `IOB_CACHE_*_ADDR` definitions
- Sub-module iob_cache_ctrl_wdog: a loadable down-counter with an expire flag. Instantiated only under the macro.

## Test plan
- SNAPSHOT, responder returns 5, 2, 7, 1: read_hit_o=5, read_miss_o=2, write_hit_o=7, write_miss_o=1; all four change in the same cycle as done_o; done_o at cycle 13.
- CLEAR: exactly one ctrl_valid_o pulse with RST_CNTRS address; err_o=0; done_o at cycle 4.
- FLUSH_INV, WTB_EMPTY reads 0, 0, 1: four requests total, the last one INVALIDATE; err_o=0.
- FLUSH_INV with POLL_MAX=3, WTB_EMPTY always 0: exactly 3 polls, no INVALIDATE, err_o=1.
- Responder silent, watchdog enabled, RESP_TO=16: err_o=2 after 16 WAIT cycles; snapshot outputs unchanged.
- reset_n_i pulsed during the 3rd SNAPSHOT read: all outputs 0 immediately; cmd_ready_o=1 after release; a cmd_valid_i held during busy is accepted only after done_o.
